// File: rtl/hash_target_cmp.sv
// hash_target_cmp: multi-cycle unsigned magnitude comparator, one CHUNK slice per cycle, MSB slice first.
// Build option: define HASH_CMP_EARLY_EXIT_EN to stop at the first differing slice (variable latency).
module hash_target_cmp #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             alb,
  output logic             aeb,
  output logic             agb
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("hash_target_cmp: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Flag vectors are packed {lt, eq, gt}.
  function automatic logic [2:0] slice_flags(input logic [CHUNK-1:0] sa,
                                             input logic [CHUNK-1:0] sb);
    logic [2:0] f;
    f = 3'b010;
    if (sa < sb)      f = 3'b100;
    else if (sa > sb) f = 3'b001;
    return f;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       flags_q, flags_d;
  logic [2:0]       slice_res;
  logic             slice_ne;
`ifndef HASH_CMP_EARLY_EXIT_EN
  logic             diff_q, diff_d;
  logic [2:0]       dflags_q, dflags_d;
`endif

  assign slice_res = slice_flags(a_q[WIDTH-1 -: CHUNK], b_q[WIDTH-1 -: CHUNK]);
  assign slice_ne  = ~slice_res[1];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    flags_d  = flags_q;
`ifndef HASH_CMP_EARLY_EXIT_EN
    diff_d   = diff_q;
    dflags_d = dflags_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
`ifndef HASH_CMP_EARLY_EXIT_EN
          diff_d  = 1'b0;
`endif
          state_d = CMP;
        end
      end
      CMP: begin
`ifdef HASH_CMP_EARLY_EXIT_EN
        if (slice_ne || cnt_q == LAST) begin
          flags_d = slice_res;
          state_d = DONE;
        end else begin
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
          cnt_d = cnt_q + 1'b1;
        end
`else
        // Constant-time walk: the first differing slice is remembered and decides the result.
        if (cnt_q == LAST) begin
          flags_d = diff_q ? dflags_q : slice_res;
          state_d = DONE;
        end else begin
          if (!diff_q && slice_ne) begin
            diff_d   = 1'b1;
            dflags_d = slice_res;
          end
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: cleared asynchronously so a reset aborts any transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      flags_q  <= 3'b000;
`ifndef HASH_CMP_EARLY_EXIT_EN
      diff_q   <= 1'b0;
      dflags_q <= 3'b000;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flags_q  <= flags_d;
`ifndef HASH_CMP_EARLY_EXIT_EN
      diff_q   <= diff_d;
      dflags_q <= dflags_d;
`endif
    end
  end

  // Operand shift registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign alb       = flags_q[2];
  assign aeb       = flags_q[1];
  assign agb       = flags_q[0];

endmodule

// File: tb/tb_hash_target_cmp.sv
// Scoreboard bench for hash_target_cmp: 256/32 directed cases plus random sweeps on 8/1 and 256/256.
module tb_hash_target_cmp;

  typedef struct {
    logic [2:0] flags;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_m, rst_s;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic         iv_m, ir_m, ov_m, or_m, lt_m, eq_m, gt_m;
  logic [255:0] a_m, b_m;
  logic         iv_8, ir_8, ov_8, or_8, lt_8, eq_8, gt_8;
  logic [7:0]   a_8, b_8;
  logic         iv_w, ir_w, ov_w, or_w, lt_w, eq_w, gt_w;
  logic [255:0] a_w, b_w;

  exp_t q_m[$];
  exp_t q_8[$];
  exp_t q_w[$];
  exp_t em_m, em_8, em_w;
  int   acc_m, acc_8, acc_w;
  logic ovp_m, ovp_8, ovp_w;

  hash_target_cmp #(.WIDTH(256), .CHUNK(32)) u_main (
    .clk(clk), .rst(rst_m), .in_valid(iv_m), .in_ready(ir_m), .a(a_m), .b(b_m),
    .out_valid(ov_m), .out_ready(or_m), .alb(lt_m), .aeb(eq_m), .agb(gt_m));

  hash_target_cmp #(.WIDTH(8), .CHUNK(1)) u_bit (
    .clk(clk), .rst(rst_s), .in_valid(iv_8), .in_ready(ir_8), .a(a_8), .b(b_8),
    .out_valid(ov_8), .out_ready(or_8), .alb(lt_8), .aeb(eq_8), .agb(gt_8));

  hash_target_cmp #(.WIDTH(256), .CHUNK(256)) u_wide (
    .clk(clk), .rst(rst_s), .in_valid(iv_w), .in_ready(ir_w), .a(a_w), .b(b_w),
    .out_valid(ov_w), .out_ready(or_w), .alb(lt_w), .aeb(eq_w), .agb(gt_w));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [255:0] x, input logic [255:0] y);
    return {x < y, x == y, x > y};
  endfunction

  // Expected cycles from accept edge to out_valid for a w-bit operand split into c-bit slices.
  function automatic int exp_lat(input logic [255:0] x, input logic [255:0] y,
                                 input int w, input int c);
    int n;
    int first;
    logic [255:0] sx, sy;
    n = w / c;
    first = n;
    for (int i = 0; i < n; i++) begin
      sx = (x << (256 - w + i * c)) >> (256 - c);
      sy = (y << (256 - w + i * c)) >> (256 - c);
      if (first == n && sx != sy) first = i;
    end
`ifdef HASH_CMP_EARLY_EXIT_EN
    return (first == n) ? n : first + 1;
`else
    return n;
`endif
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_m) ovp_m = 1'b0;
    else begin
      if (iv_m && ir_m) acc_m = cyc + 1;
      if (ov_m && !ovp_m) begin
        check("m_qdepth", q_m.size() > 0, 1);
        if (q_m.size() > 0) begin
          em_m = q_m.pop_front();
          check("m_flags", {lt_m, eq_m, gt_m}, em_m.flags);
          check("m_lat", cyc - acc_m, em_m.lat);
          check("m_onehot", $countones({lt_m, eq_m, gt_m}), 1);
        end
      end
      ovp_m = ov_m;
    end
  end

  always @(negedge clk) begin
    if (rst_s) ovp_8 = 1'b0;
    else begin
      if (iv_8 && ir_8) acc_8 = cyc + 1;
      if (ov_8 && !ovp_8) begin
        check("b_qdepth", q_8.size() > 0, 1);
        if (q_8.size() > 0) begin
          em_8 = q_8.pop_front();
          check("b_flags", {lt_8, eq_8, gt_8}, em_8.flags);
          check("b_lat", cyc - acc_8, em_8.lat);
        end
      end
      ovp_8 = ov_8;
    end
  end

  always @(negedge clk) begin
    if (rst_s) ovp_w = 1'b0;
    else begin
      if (iv_w && ir_w) acc_w = cyc + 1;
      if (ov_w && !ovp_w) begin
        check("w_qdepth", q_w.size() > 0, 1);
        if (q_w.size() > 0) begin
          em_w = q_w.pop_front();
          check("w_flags", {lt_w, eq_w, gt_w}, em_w.flags);
          check("w_lat", cyc - acc_w, em_w.lat);
        end
      end
      ovp_w = ov_w;
    end
  end

  // One transaction on the 256/32 instance; bp > 0 holds out_ready low for bp cycles of DONE.
  task automatic drive_m(input logic [255:0] av, input logic [255:0] bv, input int bp);
    exp_t e;
    bit   ok;
    e.flags = ref_cmp(av, bv);
    e.lat   = exp_lat(av, bv, 256, 32);
    q_m.push_back(e);
    a_m = av; b_m = bv; iv_m = 1'b1; or_m = (bp == 0);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = ir_m;
      @(posedge clk); #1;
    end
    if (!ok) check("m_tmo_accept", ir_m, 1);
    iv_m = 1'b0; a_m = rand256(); b_m = rand256();
    ok = ov_m;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(posedge clk); #1;
      ok = ov_m;
    end
    if (!ok) check("m_tmo_ovalid", ov_m, 1);
    for (int i = 0; i < bp; i++) begin
      check("bp_ovalid", ov_m, 1);
      check("bp_flags", {lt_m, eq_m, gt_m}, e.flags);
      check("bp_inrdy", ir_m, 0);
      iv_m = (i == 2);
      a_m = ~av; b_m = av;
      @(posedge clk); #1;
    end
    iv_m = 1'b0; or_m = 1'b1;
    @(posedge clk); #1;
    check("m_idle_inrdy", ir_m, 1);
    check("m_idle_ovalid", ov_m, 0);
    check("m_hold_flags", {lt_m, eq_m, gt_m}, e.flags);
  endtask

  task automatic sweep8(input int n);
    exp_t       e;
    bit         ok;
    logic [7:0] x, y;
    for (int i = 0; i < n; i++) begin
      x = 8'($urandom);
      y = ($urandom_range(0, 3) == 0) ? x : 8'($urandom);
      e.flags = ref_cmp(256'(x), 256'(y));
      e.lat   = exp_lat(256'(x), 256'(y), 8, 1);
      q_8.push_back(e);
      a_8 = x; b_8 = y; iv_8 = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        ok = ir_8;
        @(posedge clk); #1;
      end
      iv_8 = 1'b0;
      if (!ok) check("b_tmo_accept", ir_8, 1);
      ok = ov_8;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(posedge clk); #1;
        ok = ov_8;
      end
      if (!ok) check("b_tmo_ovalid", ov_8, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic sweepw(input int n);
    exp_t         e;
    bit           ok;
    logic [255:0] x, y;
    for (int i = 0; i < n; i++) begin
      x = rand256();
      case ($urandom_range(0, 2))
        0:       y = x;
        1:       y = x ^ (256'(1) << $urandom_range(0, 255));
        default: y = rand256();
      endcase
      e.flags = ref_cmp(x, y);
      e.lat   = exp_lat(x, y, 256, 256);
      q_w.push_back(e);
      a_w = x; b_w = y; iv_w = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        ok = ir_w;
        @(posedge clk); #1;
      end
      iv_w = 1'b0;
      if (!ok) check("w_tmo_accept", ir_w, 1);
      ok = ov_w;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(posedge clk); #1;
        ok = ov_w;
      end
      if (!ok) check("w_tmo_ovalid", ov_w, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] x, y, pat;
    bit           ok;
    rst_m = 1'b1; rst_s = 1'b1;
    iv_m = 1'b0; or_m = 1'b1; a_m = '0; b_m = '0;
    iv_8 = 1'b0; or_8 = 1'b1; a_8 = '0; b_8 = '0;
    iv_w = 1'b0; or_w = 1'b1; a_w = '0; b_w = '0;
    #3;
    check("rst_inrdy", ir_m, 0);
    check("rst_ovalid", ov_m, 0);
    check("rst_flags", {lt_m, eq_m, gt_m}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_m = 1'b0; rst_s = 1'b0;
    #1;
    check("rel_inrdy", ir_m, 1);

    pat = {8{32'hA5A5A5A5}};
    drive_m(pat, pat, 0);

    x = rand256();
    drive_m({32'h1, x[223:0]}, {32'h0, x[223:0]}, 0);

    drive_m(256'h0, 256'h1, 0);

    x = rand256(); y = x;
    x[200] = 1'b0; y[200] = 1'b1; x[3] = 1'b1; y[3] = 1'b0;
    drive_m(x, y, 0);

    drive_m(rand256(), rand256(), 5);

    // Abort in the third CMP cycle: flags from the previous result must clear at once.
    a_m = pat; b_m = pat; iv_m = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = ir_m;
      @(posedge clk); #1;
    end
    if (!ok) check("abort_tmo_accept", ir_m, 1);
    iv_m = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_m = 1'b1;
    #1;
    check("abort_ovalid", ov_m, 0);
    check("abort_flags", {lt_m, eq_m, gt_m}, 0);
    check("abort_inrdy", ir_m, 0);
    @(posedge clk); #1;
    rst_m = 1'b0;
    #1;
    check("abort_rel_inrdy", ir_m, 1);
    drive_m(pat, {pat[255:32], 32'hA5A5A5A6}, 0);

    for (int i = 0; i < 40; i++) begin
      x = rand256();
      case (i % 3)
        0:       y = x;
        1:       y = x ^ (256'(1) << $urandom_range(0, 255));
        default: y = rand256();
      endcase
      drive_m(x, y, (i % 7 == 0) ? 2 : 0);
    end

    sweep8(1000);
    sweepw(1000);

    repeat (4) @(posedge clk);
    #1;
    check("m_q_empty", q_m.size(), 0);
    check("b_q_empty", q_8.size(), 0);
    check("w_q_empty", q_w.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
